// File: rtl/seg7_pkg.sv
// Shared constants for the signed 7-segment display: segment glyphs and the converter FSM states.
// Segment order is {a,b,c,d,e,f,g}, active-high.
`timescale 1ns/1ps
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b0000001;
    localparam logic [6:0] SEG_E     = 7'b1001111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Glyph table for decimal digits 0..9; non-decimal codes render blank.
    function automatic logic [6:0] seg_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1111110;
            4'd1:    g = 7'b0110000;
            4'd2:    g = 7'b1101101;
            4'd3:    g = 7'b1111001;
            4'd4:    g = 7'b0110011;
            4'd5:    g = 7'b1011011;
            4'd6:    g = 7'b1011111;
            4'd7:    g = 7'b1110000;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1111011;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// One BCD digit to its 7-segment glyph; instantiated once per magnitude digit.
`timescale 1ns/1ps
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = seg_glyph(bcd);

endmodule

// File: rtl/signed_seg7_display.sv
// Signed/unsigned binary to sign+DIGITS decimal 7-segment display via iterative double-dabble,
// with a parallel segment bus and a scanned output. Optional macro: LEADING_ZERO_BLANK_EN.
`timescale 1ns/1ps
module signed_seg7_display
    import seg7_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    is_signed,
    input  logic [WIDTH-1:0]        din,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic [(DIGITS+1)*7-1:0] display,
    output logic [6:0]              scan_seg,
    output logic [DIGITS:0]         scan_an
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(DIGITS + 1);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t                    state, state_d;
    logic [BW-1:0]             bcd_q, bcd_adj;
    logic [WIDTH-1:0]          mag_q;
    logic [CW-1:0]             cnt_q;
    logic                      ovf_acc, neg_q, nz_q;
    logic                      load_neg;
    logic [WIDTH:0]            din_ext, mag_full;
    logic [DIGITS*7-1:0]       dig_seg, dig_shown;
    logic [6:0]                sign_seg;
    logic                      lead;
    logic [(DIGITS+1)*7-1:0]   display_d;
    logic [DW-1:0]             div_q;
    logic [PW-1:0]             pos_q, pos_d;
    logic                      div_wrap;

    // Magnitude is formed one bit wider so the most negative input negates exactly.
    assign load_neg = is_signed & din[WIDTH-1];
    assign din_ext  = {load_neg, din};
    assign mag_full = load_neg ? (~din_ext + 1'b1) : din_ext;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (load) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
            ovf_acc <= 1'b0;
            neg_q   <= 1'b0;
            nz_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    bcd_q   <= '0;
                    mag_q   <= mag_full[WIDTH-1:0];
                    cnt_q   <= CW'(WIDTH);
                    ovf_acc <= 1'b0;
                    neg_q   <= load_neg;
                    nz_q    <= |mag_full;
                end
                SHIFT: begin
                    {bcd_q, mag_q} <= {bcd_adj[BW-2:0], mag_q, 1'b0};
                    cnt_q          <= cnt_q - 1'b1;
                    // A carry out of the top nibble means the value needs more digits than we have.
                    if (bcd_adj[BW-1]) ovf_acc <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_digit_decode u_dec (
            .bcd (bcd_q[4*g +: 4]),
            .seg (dig_seg[7*g +: 7])
        );
    end

    always_comb begin
        sign_seg  = (neg_q & nz_q) ? SEG_MINUS : SEG_BLANK;
        dig_shown = ovf_acc ? {DIGITS{SEG_E}} : dig_seg;
        lead      = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        // Walk down from the top digit; the LS digit always stays visible.
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) lead = 1'b0;
            if (lead && !ovf_acc) dig_shown[7*i +: 7] = SEG_BLANK;
        end
`endif
        display_d = (state == DONE) ? {sign_seg, dig_shown} : display;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            display <= display_d;
            done    <= (state == DONE);
            if (state == DONE) ovf <= ovf_acc;
        end
    end

    assign div_wrap = (div_q == DW'(SCAN_DIV - 1));

    always_comb begin
        pos_d = pos_q;
        if (div_wrap) pos_d = (pos_q == PW'(DIGITS)) ? '0 : pos_q + 1'b1;
    end

    // scan_seg is taken from the next display value so it never lags a display update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            pos_q    <= '0;
            scan_an  <= {{DIGITS{1'b0}}, 1'b1};
            scan_seg <= '0;
        end else begin
            div_q    <= div_wrap ? '0 : div_q + 1'b1;
            pos_q    <= pos_d;
            scan_an  <= {{DIGITS{1'b0}}, 1'b1} << pos_d;
            scan_seg <= display_d[32'(pos_d)*7 +: 7];
        end
    end

endmodule
